// File: rtl/pwm_deadtime_if.sv
// APB register-window bundle between the bus master and the dead-time gate driver.
interface pwm_deadtime_if #(
  parameter int ADDR_APB = 8,
  parameter int DATA_APB = 32
);
  logic                apb_psel;
  logic [ADDR_APB-1:0] apb_paddr;
  logic                apb_pwrite;
  logic                apb_penable;
  logic [DATA_APB-1:0] apb_pwdata;
  logic [DATA_APB-1:0] apb_prdata;

  modport master (
    output apb_psel, apb_paddr, apb_pwrite, apb_penable, apb_pwdata,
    input  apb_prdata
  );

  modport slave (
    input  apb_psel, apb_paddr, apb_pwrite, apb_penable, apb_pwdata,
    output apb_prdata
  );
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary gate driver: dead-time insertion, short-pulse swallowing, latched fault shutdown.
// pwm_in sampled at edge k turns the old side off at k and the new side on at k+DT; fault pin to gates low in 3 edges; no backpressure.
module pwm_deadtime #(
  parameter int ADDR_APB = 8,
  parameter int DATA_APB = 32,
  parameter int DT_W     = 16
) (
  input  logic          apb_pclk,
  input  logic          apb_prst,
  pwm_deadtime_if.slave apb,
  input  logic          pwm_in,
  input  logic          fault,
  output logic          pwm_h,
  output logic          pwm_l,
  output logic          fault_irq
);

  localparam logic [7:0]      ADDR_CTRL   = 8'h40;
  localparam logic [7:0]      ADDR_DT     = 8'h44;
  localparam logic [7:0]      ADDR_STATUS = 8'h48;
  localparam logic [DT_W-1:0] CNT_ONE     = DT_W'(1);
  localparam logic [DT_W-1:0] CNT_ZERO    = '0;

  // One-hot so that the L_ON and H_ON bits can drive the gates directly.
  typedef enum logic [5:0] {
    ST_OFF    = 6'b000001,
    ST_DEAD_L = 6'b000010,
    ST_L_ON   = 6'b000100,
    ST_DEAD_H = 6'b001000,
    ST_H_ON   = 6'b010000,
    ST_FAULT  = 6'b100000
  } state_t;

  state_t              state_q;
  logic [DT_W-1:0]     cnt_q;
  logic [DT_W-1:0]     dt_q;
  logic                en_q;
  logic                fie_q;
  logic                fault_q;
  logic                from_h_q;
  logic                fault_m;
  logic                fault_s;
  logic [2:0]          state_code;
  logic [ADDR_APB-1:0] addr;
  logic [7:0]          reg_addr;
  logic                wr_en;
  logic                rd_setup;
  logic                fclr_wr;
  logic [DATA_APB-1:0] rd_mux;
  logic [DATA_APB-1:0] prdata_q;
  logic                unused_wdata;

  assign addr         = apb.apb_paddr;
  assign reg_addr     = addr[7:0];
  assign wr_en        = apb.apb_psel & apb.apb_penable & apb.apb_pwrite;
  assign rd_setup     = apb.apb_psel & ~apb.apb_penable & ~apb.apb_pwrite;
  assign fclr_wr      = wr_en && (reg_addr == ADDR_CTRL) && apb.apb_pwdata[1];
  assign unused_wdata = ^apb.apb_pwdata[DATA_APB-1:DT_W];

  assign pwm_l     = state_q[2];
  assign pwm_h     = state_q[4];
  assign fault_irq = fault_q & fie_q;

  assign apb.apb_prdata = prdata_q;

  always_comb begin
    state_code = 3'd0;
    case (state_q)
      ST_OFF:    state_code = 3'd0;
      ST_DEAD_L: state_code = 3'd1;
      ST_L_ON:   state_code = 3'd2;
      ST_DEAD_H: state_code = 3'd3;
      ST_H_ON:   state_code = 3'd4;
      ST_FAULT:  state_code = 3'd5;
      default:   state_code = 3'd7;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_CTRL:   rd_mux = DATA_APB'({fie_q, 1'b0, en_q});
      ADDR_DT:     rd_mux = DATA_APB'(dt_q);
      ADDR_STATUS: rd_mux = DATA_APB'({state_code, pwm_l, pwm_h, fault_q});
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      en_q     <= 1'b0;
      fie_q    <= 1'b0;
      dt_q     <= '0;
      prdata_q <= '0;
    end else begin
      if (wr_en) begin
        case (reg_addr)
          ADDR_CTRL: begin
            en_q  <= apb.apb_pwdata[0];
            fie_q <= apb.apb_pwdata[2];
          end
          ADDR_DT: dt_q <= apb.apb_pwdata[DT_W-1:0];
          default: ;
        endcase
      end
      // Data is captured in the setup phase and held through the access phase.
      if (rd_setup) begin
        prdata_q <= rd_mux;
      end
    end
  end

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      fault_m <= 1'b0;
      fault_s <= 1'b0;
    end else begin
      fault_m <= fault;
      fault_s <= fault_m;
    end
  end

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      from_h_q <= 1'b0;
      fault_q  <= 1'b0;
    end else if (fault_s) begin
      state_q <= ST_FAULT;
      fault_q <= 1'b1;
    end else if (state_q == ST_FAULT) begin
      if (fclr_wr) begin
        fault_q <= 1'b0;
        state_q <= ST_OFF;
      end
    end else if (!en_q) begin
      state_q <= ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          from_h_q <= 1'b0;
          cnt_q    <= dt_q;
          state_q  <= (dt_q == CNT_ZERO) ? ST_L_ON : ST_DEAD_L;
        end
        ST_DEAD_L: begin
          // Returning to H is safe mid-gap only if H was the side that just turned off.
          if (from_h_q && pwm_in) begin
            state_q <= ST_H_ON;
          end else if (cnt_q <= CNT_ONE) begin
            state_q <= pwm_in ? ST_H_ON : ST_L_ON;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_L_ON: begin
          if (pwm_in) begin
            cnt_q   <= dt_q;
            state_q <= (dt_q == CNT_ZERO) ? ST_H_ON : ST_DEAD_H;
          end
        end
        ST_DEAD_H: begin
          if (!pwm_in) begin
            state_q <= ST_L_ON;
          end else if (cnt_q <= CNT_ONE) begin
            state_q <= ST_H_ON;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_H_ON: begin
          if (!pwm_in) begin
            from_h_q <= 1'b1;
            cnt_q    <= dt_q;
            state_q  <= (dt_q == CNT_ZERO) ? ST_L_ON : ST_DEAD_L;
          end
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: expected values queued at stimulus time, compared when the DUT responds.
module tb_pwm_deadtime;

  logic clk;
  logic rst;
  logic pwm_in;
  logic fault;
  logic pwm_h;
  logic pwm_l;
  logic fault_irq;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  pwm_deadtime_if #(.ADDR_APB(8), .DATA_APB(32)) apb_bus ();

  pwm_deadtime #(.ADDR_APB(8), .DATA_APB(32), .DT_W(16)) dut (
    .apb_pclk  (clk),
    .apb_prst  (rst),
    .apb       (apb_bus),
    .pwm_in    (pwm_in),
    .fault     (fault),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l),
    .fault_irq (fault_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // The two gates must never be on together.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ((pwm_h & pwm_l) === 1'b0) passed++;
      else $error("FAIL overlap observed h=%0b l=%0b expected never both 1", pwm_h, pwm_l);
    end
  end

  function automatic logic [31:0] gates();
    return {29'd0, fault_irq, pwm_h, pwm_l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty observed=%h expected=<nothing queued>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  // exp = {fault_irq, pwm_h, pwm_l} after the next edge.
  task automatic step_gates(input string tag, input logic [2:0] exp);
    push(tag, {29'd0, exp});
    tick();
    pop_chk(gates());
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    apb_bus.apb_psel    = 1'b1;
    apb_bus.apb_pwrite  = 1'b1;
    apb_bus.apb_penable = 1'b0;
    apb_bus.apb_paddr   = addr;
    apb_bus.apb_pwdata  = data;
    tick();
    apb_bus.apb_penable = 1'b1;
    tick();
    apb_bus.apb_psel    = 1'b0;
    apb_bus.apb_penable = 1'b0;
    apb_bus.apb_pwrite  = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    push(tag, exp);
    apb_bus.apb_psel    = 1'b1;
    apb_bus.apb_pwrite  = 1'b0;
    apb_bus.apb_penable = 1'b0;
    apb_bus.apb_paddr   = addr;
    tick();
    apb_bus.apb_penable = 1'b1;
    tick();
    pop_chk(apb_bus.apb_prdata);
    apb_bus.apb_psel    = 1'b0;
    apb_bus.apb_penable = 1'b0;
  endtask

  initial begin
    logic [11:0] pat;
    int          ph;
    logic        pin;
    logic        eh;
    logic        el;

    rst                 = 1'b1;
    pwm_in              = 1'b0;
    fault               = 1'b0;
    apb_bus.apb_psel    = 1'b0;
    apb_bus.apb_pwrite  = 1'b0;
    apb_bus.apb_penable = 1'b0;
    apb_bus.apb_paddr   = '0;
    apb_bus.apb_pwdata  = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    push("rst_gates", 32'd0);
    pop_chk(gates());
    apb_read(8'h40, 32'h0, "rst_ctrl");
    apb_read(8'h44, 32'h0, "rst_dt");
    apb_read(8'h48, 32'h0, "rst_status");
    apb_write(8'h4C, 32'hFFFF_FFFF);
    apb_read(8'h4C, 32'h0, "unmapped_read");

    // DT=4 start-up: four cycles of both low, then L on
    apb_write(8'h44, 32'd4);
    apb_write(8'h40, 32'h5);
    for (int j = 1; j <= 6; j++) begin
      step_gates("dt4_startup", (j >= 5) ? 3'b001 : 3'b000);
    end
    apb_read(8'h44, 32'd4, "dt4_readback");

    // DT=4 square wave, period 20, high 10
    for (int j = 0; j < 60; j++) begin
      ph     = j % 20;
      pwm_in = (ph < 10);
      eh     = (ph >= 4) && (ph < 10);
      el     = (ph >= 14);
      step_gates("dt4_wave", {1'b0, eh, el});
    end

    // DT=6 with a 3-cycle pulse: swallowed
    apb_write(8'h44, 32'hABCD_0006);
    apb_read(8'h44, 32'h0000_0006, "dt_upper_bits");
    for (int j = 0; j < 8; j++) begin
      pwm_in = (j < 3);
      step_gates("short_pulse", (j < 3) ? 3'b000 : 3'b001);
    end

    // DT=0: direct complementary switching
    apb_write(8'h44, 32'd0);
    pat = 12'b0110_1001_1100;
    for (int j = 0; j < 12; j++) begin
      pin    = pat[j];
      pwm_in = pin;
      step_gates("dt0_toggle", {1'b0, pin, ~pin});
    end

    // DT=8 gap with DT=2 written mid-count, then symmetric H re-entry
    apb_write(8'h44, 32'd8);
    for (int j = 0; j < 26; j++) begin
      pwm_in = (j <= 11) || (j >= 18 && j <= 20) || (j >= 22);
      if (j == 1) begin
        apb_bus.apb_psel    = 1'b1;
        apb_bus.apb_pwrite  = 1'b1;
        apb_bus.apb_penable = 1'b0;
        apb_bus.apb_paddr   = 8'h44;
        apb_bus.apb_pwdata  = 32'd2;
      end else if (j == 2) begin
        apb_bus.apb_penable = 1'b1;
      end else if (j == 3) begin
        apb_bus.apb_psel    = 1'b0;
        apb_bus.apb_penable = 1'b0;
        apb_bus.apb_pwrite  = 1'b0;
      end
      eh = (j >= 8 && j <= 11) || (j == 20) || (j >= 22);
      el = (j >= 14 && j <= 17);
      step_gates("dt_midcount", {1'b0, eh, el});
    end

    // Two-cycle fault pulse while H is on
    for (int j = 0; j < 5; j++) begin
      fault = (j < 2);
      step_gates("fault_pulse", (j < 2) ? 3'b010 : 3'b100);
    end
    apb_read(8'h48, 32'h29, "fault_status");
    apb_read(8'h40, 32'h5, "fault_ctrl");

    // Clear attempted while the fault pin is still high: ignored
    fault = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step_gates("fault_hold", 3'b100);
    end
    apb_write(8'h40, 32'h7);
    apb_read(8'h48, 32'h29, "fclr_while_fault");

    // Fault drops: still latched until software clears it
    fault  = 1'b0;
    pwm_in = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step_gates("fault_latched", 3'b100);
    end
    apb_read(8'h48, 32'h29, "latch_after_drop");
    apb_read(8'h40, 32'h5, "ctrl_fclr_reads0");
    apb_write(8'h40, 32'h7);
    push("fclr_to_off", 32'd0);
    pop_chk(gates());
    for (int j = 1; j <= 3; j++) begin
      step_gates("restart", (j == 3) ? 3'b001 : 3'b000);
    end
    apb_read(8'h48, 32'h14, "restart_status");

    // Asynchronous reset mid-operation
    #3;
    rst = 1'b1;
    #1;
    push("async_rst_gates", 32'd0);
    pop_chk(gates());
    tick();
    rst = 1'b0;
    apb_read(8'h40, 32'h0, "post_rst_ctrl");
    apb_read(8'h44, 32'h0, "post_rst_dt");
    apb_read(8'h48, 32'h0, "post_rst_status");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
